// File: rtl/qpp_pkg.sv
// Shared types, sizing constants and the modular-add helper used by the
// QPP extrinsic interleaver.
package qpp_pkg;

    localparam int K_MAX  = 6144;
    localparam int ADDR_W = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Reference LTE block configurations (K, f1, f2)
    localparam int REF_K  [3] = '{40, 512, 6144};
    localparam int REF_F1 [3] = '{3, 31, 263};
    localparam int REF_F2 [3] = '{10, 64, 480};

    // (a + b) mod k, valid only when both operands are already below k
    function automatic logic [ADDR_W-1:0] mod_add(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] b,
        input logic [ADDR_W-1:0] k
    );
        logic [ADDR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k}) begin
            s = s - {1'b0, k};
        end
        return s[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// Recursive QPP address generator: pi(x+1) = pi(x) + g(x), g(x+1) = g(x) + 2*f2,
// everything mod K, so no multiplier is needed.
module qpp_addr_gen
    import qpp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              step,
    input  logic [ADDR_W-1:0] k,
    input  logic [ADDR_W-1:0] g_init,
    input  logic [ADDR_W-1:0] f2x2,
    output logic [ADDR_W-1:0] i,
    output logic [ADDR_W-1:0] pi,
    output logic              last
);
    logic [ADDR_W-1:0] i_q;
    logic [ADDR_W-1:0] pi_q;
    logic [ADDR_W-1:0] g_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            i_q  <= '0;
            pi_q <= '0;
            g_q  <= '0;
        end else if (init) begin
            i_q  <= '0;
            pi_q <= '0;
            g_q  <= g_init;
        end else if (step) begin
            i_q  <= i_q + ADDR_W'(1);
            pi_q <= mod_add(pi_q, g_q, k);
            g_q  <= mod_add(g_q, f2x2, k);
        end
    end

    assign i    = i_q;
    assign pi   = pi_q;
    assign last = (i_q == k - ADDR_W'(1));

endmodule

// File: rtl/qpp_extrinsic_interleaver.sv
// Buffers one block of extrinsic samples and replays it in QPP interleaved or
// de-interleaved order as the a-priori stream for the next half-iteration.
//   state | meaning
//   IDLE  | waiting for a block configuration
//   FILL  | writing K extrinsic samples into the RAM
//   DRAIN | reading K samples out through the output register
module qpp_extrinsic_interleaver #(
    parameter int DATA_W = 16,
    parameter int K_MAX  = qpp_pkg::K_MAX,
    parameter int ADDR_W = qpp_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       blklen,
    input  logic [ADDR_W-1:0] f1,
    input  logic [ADDR_W-1:0] f2,
    input  logic              deint,
    input  logic              valid_blklen,
    input  logic [DATA_W-1:0] extrinsic,
    input  logic              valid_extrinsic,
    output logic [DATA_W-1:0] apriori,
    output logic              valid_apriori,
    input  logic              apriori_ready,
    output logic              busy,
    output logic              err
);
    import qpp_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d, g0_q, g0_d, f2x2_q, f2x2_d;
    logic              deint_q, deint_d, err_q, err_d;
    logic              rd_done_q, rd_done_d, valid_q, valid_d;
    logic [DATA_W-1:0] apriori_q;
    logic              cfg_ok, ag_init, ag_step, ag_last, wr_en, rd_en;
    logic [ADDR_W-1:0] ag_i, ag_pi, blk_k, wr_addr, rd_addr;
    logic [DATA_W-1:0] mem [K_MAX];

    assign blk_k   = blklen[ADDR_W-1:0];
    assign cfg_ok  = (blklen >= 16'd8) && (blklen <= 16'(K_MAX));
    assign wr_addr = deint_q ? ag_pi : ag_i;
    assign rd_addr = deint_q ? ag_i : ag_pi;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        g0_d      = g0_q;
        f2x2_d    = f2x2_q;
        deint_d   = deint_q;
        err_d     = err_q;
        rd_done_d = rd_done_q;
        valid_d   = valid_q;
        ag_init   = 1'b0;
        ag_step   = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                rd_done_d = 1'b0;
                if (valid_blklen) begin
                    if (cfg_ok) begin
                        k_d     = blk_k;
                        g0_d    = mod_add(f1, f2, blk_k);
                        f2x2_d  = mod_add(f2, f2, blk_k);
                        deint_d = deint;
                        err_d   = 1'b0;
                        ag_init = 1'b1;
                        state_d = FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (valid_extrinsic) err_d = 1'b1;
            end
            FILL: begin
                if (valid_blklen) err_d = 1'b1;
                if (valid_extrinsic) begin
                    wr_en   = 1'b1;
                    ag_step = 1'b1;
                    if (ag_last) begin
                        ag_init = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (valid_blklen || valid_extrinsic) err_d = 1'b1;
                rd_en = !rd_done_q && (!valid_q || apriori_ready);
                if (rd_en) begin
                    ag_step = 1'b1;
                    valid_d = 1'b1;
                    if (ag_last) rd_done_d = 1'b1;
                end else if (apriori_ready) begin
                    valid_d = 1'b0;
                end
                // Leave once every read has issued and the final sample is taken
                if (rd_done_q && valid_q && apriori_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            g0_q      <= '0;
            f2x2_q    <= '0;
            deint_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_done_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            g0_q      <= g0_d;
            f2x2_q    <= f2x2_d;
            deint_q   <= deint_d;
            err_q     <= err_d;
            rd_done_q <= rd_done_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= extrinsic;
    end

    // Registered RAM read port doubles as the output holding register
    always_ff @(posedge clk) begin
        if (!rst) begin
            apriori_q <= '0;
        end else if (rd_en) begin
            apriori_q <= mem[rd_addr];
        end
    end

    qpp_addr_gen u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .init   (ag_init),
        .step   (ag_step),
        .k      (k_q),
        .g_init (g0_d),
        .f2x2   (f2x2_q),
        .i      (ag_i),
        .pi     (ag_pi),
        .last   (ag_last)
    );

    assign apriori       = apriori_q;
    assign valid_apriori = valid_q;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;

endmodule

// File: tb/tb_qpp_extrinsic_interleaver.sv
// Randomized bench for the QPP extrinsic interleaver against a direct
// pi(x) = (f1*x + f2*x^2) mod K reference model.
module tb_qpp_extrinsic_interleaver;
    import qpp_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   blklen;
    logic [12:0]   f1, f2;
    logic          deint, valid_blklen;
    logic [DW-1:0] extrinsic;
    logic          valid_extrinsic;
    logic [DW-1:0] apriori;
    logic          valid_apriori, apriori_ready, busy, err;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] ext  [K_MAX];
    logic [DW-1:0] expv [K_MAX];
    logic [DW-1:0] gotv [K_MAX];
    logic [DW-1:0] itl  [K_MAX];

    always #5 clk = ~clk;

    qpp_extrinsic_interleaver dut (
        .clk             (clk),
        .rst             (rst),
        .blklen          (blklen),
        .f1              (f1),
        .f2              (f2),
        .deint           (deint),
        .valid_blklen    (valid_blklen),
        .extrinsic       (extrinsic),
        .valid_extrinsic (valid_extrinsic),
        .apriori         (apriori),
        .valid_apriori   (valid_apriori),
        .apriori_ready   (apriori_ready),
        .busy            (busy),
        .err             (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp(input int k);
        for (int x = 0; x < k; x++) ext[x] = DW'(x);
    endtask

    task automatic fill_rand(input int k);
        for (int x = 0; x < k; x++) ext[x] = DW'($urandom);
    endtask

    // Sends config + K samples from ext[], drains and checks against the model
    task automatic run_block(input int k, input int f1v, input int f2v,
                             input bit dint, input bit bp, input bit inject);
        longint p;
        int cnt, cyc, first_cyc, last_cyc;
        bit prev_stall;
        logic [DW-1:0] prev_data;
        for (int x = 0; x < k; x++) begin
            p = (longint'(f1v) * x + longint'(f2v) * x * x) % k;
            if (!dint) expv[x] = ext[int'(p)];
            else       expv[int'(p)] = ext[x];
        end
        blklen = 16'(k); f1 = 13'(f1v); f2 = 13'(f2v); deint = dint;
        valid_blklen = 1'b1;
        tick();
        valid_blklen = 1'b0;
        chk("busy_after_cfg", 32'(busy), 32'd1);
        chk("err_after_cfg", 32'(err), 32'd0);
        for (int x = 0; x < k; x++) begin
            extrinsic = ext[x];
            valid_extrinsic = 1'b1;
            if (inject && x == 5) begin
                valid_blklen = 1'b1;
                blklen = 16'd100;
            end
            tick();
            valid_blklen = 1'b0;
        end
        valid_extrinsic = 1'b0;
        if (inject) chk("err_blklen_in_fill", 32'(err), 32'd1);
        cnt = 0; cyc = 1; first_cyc = -1; last_cyc = -1;
        prev_stall = 1'b0; prev_data = '0;
        while (cnt < k && cyc < 8 * k + 100) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(valid_apriori), 32'd1);
                chk("stall_data", 32'(apriori), 32'(prev_data));
            end
            if (valid_apriori && first_cyc < 0) first_cyc = cyc;
            apriori_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (inject && cyc == k / 2) begin
                valid_extrinsic = 1'b1;
                extrinsic = 16'hdead;
            end
            if (valid_apriori && apriori_ready) begin
                gotv[cnt] = apriori;
                chk("data", 32'(apriori), 32'(expv[cnt]));
                cnt++;
                last_cyc = cyc;
            end
            prev_stall = valid_apriori && !apriori_ready;
            prev_data = apriori;
            tick();
            valid_extrinsic = 1'b0;
            cyc++;
        end
        apriori_ready = 1'b1;
        chk("out_count", 32'(cnt), 32'(k));
        chk("busy_fall", 32'(busy), 32'd0);
        chk("valid_after_last", 32'(valid_apriori), 32'd0);
        if (!bp) begin
            chk("first_latency", 32'(first_cyc), 32'd2);
            chk("burst_len", 32'(last_cyc - first_cyc + 1), 32'(k));
        end
        if (inject) chk("err_ext_in_drain", 32'(err), 32'd1);
        else        chk("err_clean", 32'(err), 32'd0);
        tick();
        chk("no_extra_output", 32'(valid_apriori), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; blklen = '0; f1 = '0; f2 = '0; deint = 1'b0;
        valid_blklen = 1'b0; extrinsic = '0; valid_extrinsic = 1'b0;
        apriori_ready = 1'b1;
        tick(); tick();
        chk("rst_apriori", 32'(apriori), 32'd0);
        chk("rst_valid", 32'(valid_apriori), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick();

        // Interleave ramp: known head of the sequence
        fill_ramp(REF_K[0]);
        run_block(REF_K[0], REF_F1[0], REF_F2[0], 1'b0, 1'b0, 1'b0);
        chk("itl_pos0", 32'(gotv[0]), 32'd0);
        chk("itl_pos1", 32'(gotv[1]), 32'd13);
        chk("itl_pos2", 32'(gotv[2]), 32'd6);
        chk("itl_pos3", 32'(gotv[3]), 32'd19);
        for (int j = 0; j < REF_K[0]; j++) itl[j] = gotv[j];

        // De-interleaving the interleaved ramp must give identity
        for (int j = 0; j < REF_K[0]; j++) ext[j] = itl[j];
        run_block(REF_K[0], REF_F1[0], REF_F2[0], 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < REF_K[0]; j++) chk("identity", 32'(gotv[j]), 32'(j));

        fill_ramp(REF_K[0]);
        run_block(REF_K[0], REF_F1[0], REF_F2[0], 1'b1, 1'b0, 1'b0);
        chk("deint_pos0", 32'(gotv[0]), 32'd0);
        chk("deint_pos6", 32'(gotv[6]), 32'd2);
        chk("deint_pos13", 32'(gotv[13]), 32'd1);
        chk("deint_pos19", 32'(gotv[19]), 32'd3);

        for (int c = 1; c < 3; c++) begin
            fill_rand(REF_K[c]);
            run_block(REF_K[c], REF_F1[c], REF_F2[c], 1'b0, 1'b0, 1'b0);
            fill_rand(REF_K[c]);
            run_block(REF_K[c], REF_F1[c], REF_F2[c], 1'b1, 1'b0, 1'b0);
        end

        for (int r = 0; r < 4; r++) begin
            fill_rand(REF_K[0]);
            run_block(REF_K[0], REF_F1[0], REF_F2[0], 1'(r & 1), 1'b1, 1'b0);
        end

        // Too-short block is rejected
        blklen = 16'd7; f1 = 13'd3; f2 = 13'd10; deint = 1'b0;
        valid_blklen = 1'b1;
        tick();
        valid_blklen = 1'b0;
        chk("k7_err", 32'(err), 32'd1);
        chk("k7_busy", 32'(busy), 32'd0);
        tick();
        chk("k7_busy_hold", 32'(busy), 32'd0);

        // Stray inputs during FILL/DRAIN must not disturb the block
        fill_rand(REF_K[0]);
        run_block(REF_K[0], REF_F1[0], REF_F2[0], 1'b0, 1'b0, 1'b1);

        blklen = 16'(REF_K[0]);
        valid_blklen = 1'b1;
        tick();
        valid_blklen = 1'b0;
        chk("err_cleared_by_cfg", 32'(err), 32'd0);
        for (int x = 0; x < 10; x++) begin
            extrinsic = DW'($urandom);
            valid_extrinsic = 1'b1;
            if (x == 3) valid_blklen = 1'b1;
            tick();
            valid_blklen = 1'b0;
        end
        chk("err_before_reset", 32'(err), 32'd1);
        rst = 1'b0;
        tick();
        valid_extrinsic = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid_apriori), 32'd0);
        chk("midrst_apriori", 32'(apriori), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick();
        fill_rand(REF_K[0]);
        run_block(REF_K[0], REF_F1[0], REF_F2[0], 1'b0, 1'b0, 1'b0);

        // Sample offered while IDLE is flagged
        valid_extrinsic = 1'b1;
        tick();
        valid_extrinsic = 1'b0;
        chk("err_ext_in_idle", 32'(err), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
